// File: rtl/multi_dataflow_outstream_ctrl.sv
// multi_dataflow_outstream_ctrl
//
// Collects a fixed-length job of beats from the engine's output stream and
// forwards them to the streamer through a 2-entry registered FIFO.
// Tracks accepted and delivered beat counts, pulses done_o once the job has
// fully drained, and flags stray input beats offered outside RUN.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              synchronous soft clear (flush + return to IDLE)
//   start_i, len_i       job start strobe and beat count (sampled in IDLE)
//   in_valid_i/in_ready_o/in_data_i      sink stream from the engine
//   out_valid_o/out_ready_i/out_data_o   source stream to the streamer
//   out_strb_o           byte strobes, always all-ones
//   cnt_o                beats delivered downstream in the current job
//   busy_o, done_o, overflow_o           status
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start_i; FIFO empty
// RUN   | accepting beats until len beats have been taken
// DRAIN | all beats accepted, waiting for the FIFO to empty
// DONE  | single-cycle done pulse, then back to IDLE

module multi_dataflow_outstream_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [CNT_WIDTH-1:0]    len_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    output logic [DATA_WIDTH/8-1:0] out_strb_o,
    output logic [CNT_WIDTH-1:0]    cnt_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    overflow_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   len_q, len_d;
    logic [CNT_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0]  mem0_q, mem0_d;
    logic [DATA_WIDTH-1:0]  mem1_q, mem1_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             fill_q, fill_d;

    logic push;
    logic pop;

    // Gating ready with clear_i avoids handshaking a beat that the clear
    // would immediately discard.
    assign in_ready_o  = (state_q == RUN) && (fill_q != 2'd2) &&
                         (acc_q < len_q) && !clear_i;
    assign out_valid_o = (fill_q != 2'd0);
    assign out_data_o  = rd_ptr_q ? mem1_q : mem0_q;
    assign out_strb_o  = '1;
    assign cnt_o       = cnt_q;
    assign busy_o      = (state_q == RUN) || (state_q == DRAIN);
    assign done_o      = (state_q == DONE);
    assign overflow_o  = ovf_q;

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;

        if (push) begin
            if (wr_ptr_q) begin
                mem1_d = in_data_i;
            end else begin
                mem0_d = in_data_i;
            end
            wr_ptr_d = ~wr_ptr_q;
            acc_d    = acc_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case ({push, pop})
            2'b10:   fill_d = fill_q + 2'd1;
            2'b01:   fill_d = fill_q - 2'd1;
            default: fill_d = fill_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d   = len_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len_i != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // Leave RUN on the edge that accepts the final beat.
                if (push && ((acc_q + 1'b1) == len_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Nothing is pushed in DRAIN, so fill_d==0 means empty with
                // no pop still outstanding.
                if (fill_d == 2'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Evaluated after the start clear so a stray beat in the start
        // cycle is still recorded.
        if (in_valid_i && (state_q != RUN)) begin
            ovf_d = 1'b1;
        end

        if (clear_i) begin
            state_d  = IDLE;
            acc_d    = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            fill_d   = 2'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            len_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            fill_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

endmodule

// File: tb/tb_multi_dataflow_outstream_ctrl.sv
module tb_multi_dataflow_outstream_ctrl;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          start_i;
    logic [CW-1:0] len_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic [DW/8-1:0] out_strb_o;
    logic [CW-1:0] cnt_o;
    logic          busy_o;
    logic          done_o;
    logic          overflow_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] exp_q[$];
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;

    multi_dataflow_outstream_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .start_i    (start_i),
        .len_i      (len_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .out_strb_o (out_strb_o),
        .cnt_o      (cnt_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [CW-1:0] len);
        start_i = 1'b1;
        len_i   = len;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("done_seen", seen, 1);
    endtask

    // Scoreboard monitor: pops an expected beat on every source handshake
    // and checks that a stalled beat does not change.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", out_valid_o, 1);
                chk("stall_data", out_data_o, stall_data);
            end
            if (out_valid_o && out_ready_i) begin
                chk("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    chk("out_data", out_data_o, exp_q.pop_front());
                end
            end
            stall_prev = out_valid_o && !out_ready_i && !clear_i;
            stall_data = out_data_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int cyc;

        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        start_i     = 1'b0;
        len_i       = '0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b1;

        // Reset values, checked before any clock edge.
        #2;
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_data", out_data_o, 0);
        chk("rst_cnt", cnt_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("strb_ones", out_strb_o, 4'hF);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Streaming job, len=8, no backpressure.
        do_start(8);
        chk("s1_busy", busy_o, 1);
        acc = 0;
        cyc = 0;
        while (acc < 8 && cyc < 40) begin
            in_valid_i = 1'b1;
            in_data_i  = DW'(acc);
            if (in_ready_o) begin
                exp_q.push_back(DW'(acc));
                acc++;
                tick();
                if (acc == 1) begin
                    chk("s1_lat_valid", out_valid_o, 1);
                    chk("s1_lat_data", out_data_o, 0);
                end
            end else begin
                tick();
            end
            cyc++;
        end
        in_valid_i = 1'b0;
        chk("s1_accepted", acc, 8);
        chk("s1_cycles", cyc, 8);
        chk("s1_not_done_yet", done_o, 0);
        tick();
        chk("s1_done", done_o, 1);
        chk("s1_busy_done", busy_o, 0);
        chk("s1_cnt", cnt_o, 8);
        tick();
        chk("s1_done_once", done_o, 0);
        chk("s1_cnt_hold", cnt_o, 8);
        chk("s1_ovf", overflow_o, 0);

        // Backpressure, len=4.
        do_start(4);
        out_ready_i = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid_i = 1'b1;
            in_data_i  = DW'(32'h10 + acc);
            if (in_ready_o) begin
                exp_q.push_back(DW'(32'h10 + acc));
                acc++;
            end
            tick();
        end
        chk("s2_accepted_stall", acc, 2);
        chk("s2_ready_low", in_ready_o, 0);
        chk("s2_head_data", out_data_o, 32'h10);
        chk("s2_cnt_stall", cnt_o, 0);
        out_ready_i = 1'b1;
        cyc = 0;
        while (acc < 4 && cyc < 20) begin
            in_valid_i = 1'b1;
            in_data_i  = DW'(32'h10 + acc);
            if (in_ready_o) begin
                exp_q.push_back(DW'(32'h10 + acc));
                acc++;
            end
            tick();
            cyc++;
        end
        in_valid_i = 1'b0;
        chk("s2_accepted", acc, 4);
        wait_done(20);
        chk("s2_cnt", cnt_o, 4);
        chk("s2_ovf", overflow_o, 0);
        tick();

        // Zero-length job.
        do_start(0);
        chk("s3_busy", busy_o, 0);
        chk("s3_done", done_o, 1);
        chk("s3_ready", in_ready_o, 0);
        tick();
        chk("s3_done_once", done_o, 0);
        chk("s3_cnt", cnt_o, 0);

        // Extra beat, len=2.
        do_start(2);
        for (int c = 0; c < 2; c++) begin
            in_valid_i = 1'b1;
            in_data_i  = DW'(32'h20 + c);
            chk("s4_ready", in_ready_o, 1);
            exp_q.push_back(DW'(32'h20 + c));
            tick();
        end
        in_data_i = 32'h22;
        chk("s4_third_refused", in_ready_o, 0);
        tick();
        in_valid_i = 1'b0;
        chk("s4_ovf_set", overflow_o, 1);
        chk("s4_done", done_o, 1);
        chk("s4_cnt", cnt_o, 2);
        tick();
        chk("s4_ovf_held", overflow_o, 1);
        do_start(1);
        chk("s4_ovf_cleared", overflow_o, 0);
        in_valid_i = 1'b1;
        in_data_i  = 32'h30;
        chk("s4_ready_next", in_ready_o, 1);
        exp_q.push_back(32'h30);
        tick();
        in_valid_i = 1'b0;
        wait_done(10);
        chk("s4_cnt_next", cnt_o, 1);
        tick();

        // start_i during RUN must not change the latched length.
        do_start(3);
        acc = 0;
        for (int c = 0; c < 10 && acc < 3; c++) begin
            in_valid_i = 1'b1;
            in_data_i  = DW'(32'h40 + acc);
            start_i    = (acc == 1);
            len_i      = 7;
            if (in_ready_o) begin
                exp_q.push_back(DW'(32'h40 + acc));
                acc++;
            end
            tick();
        end
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        chk("s5_ready_after_len", in_ready_o, 0);
        wait_done(10);
        chk("s5_cnt", cnt_o, 3);
        tick();

        // Clear mid-job with two beats buffered.
        do_start(6);
        in_valid_i  = 1'b1;
        in_data_i   = 32'hA0;
        out_ready_i = 1'b1;
        exp_q.push_back(32'hA0);
        tick();
        in_data_i = 32'hA1;
        exp_q.push_back(32'hA1);
        tick();
        in_data_i   = 32'hA2;
        out_ready_i = 1'b0;
        exp_q.push_back(32'hA2);
        tick();
        in_valid_i = 1'b0;
        chk("s6_buffered", out_valid_o, 1);
        chk("s6_cnt_before", cnt_o, 1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        exp_q.delete();
        chk("s6_out_valid", out_valid_o, 0);
        chk("s6_cnt", cnt_o, 0);
        chk("s6_busy", busy_o, 0);
        chk("s6_done", done_o, 0);
        tick();
        chk("s6_no_done", done_o, 0);
        out_ready_i = 1'b1;

        // Asynchronous reset during DRAIN.
        do_start(2);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'h50;
        tick();
        in_data_i = 32'h51;
        tick();
        in_valid_i = 1'b0;
        chk("s7_busy_drain", busy_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        exp_q.delete();
        chk("s7_rst_out_valid", out_valid_o, 0);
        chk("s7_rst_out_data", out_data_o, 0);
        chk("s7_rst_busy", busy_o, 0);
        chk("s7_rst_ready", in_ready_o, 0);
        chk("s7_rst_cnt", cnt_o, 0);
        chk("s7_rst_done", done_o, 0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        out_ready_i = 1'b1;
        do_start(1);
        chk("s7_start_after_rst", busy_o, 1);
        in_valid_i = 1'b1;
        in_data_i  = 32'h60;
        chk("s7_ready", in_ready_o, 1);
        exp_q.push_back(32'h60);
        tick();
        in_valid_i = 1'b0;
        wait_done(10);
        chk("s7_cnt", cnt_o, 1);
        tick();
        tick();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_dataflow_outstream_ctrl.md
MULTI_DATAFLOW_OUTSTREAM_CTRL -- requirements
Module: multi_dataflow_outstream_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: stream data width in bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the length and count fields.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port clear_i, input, 1: synchronous soft clear.
REQ-006 SHALL have port start_i, input, 1: job start strobe.
REQ-007 SHALL have port len_i, input, CNT_WIDTH: expected beat count, sampled on an accepted start.
REQ-008 SHALL have ports in_valid_i (input, 1), in_ready_o (output, 1), in_data_i (input, DATA_WIDTH): sink stream from the engine output.
REQ-009 SHALL have ports out_valid_o (output, 1), out_ready_i (input, 1), out_data_o (output, DATA_WIDTH), out_strb_o (output, DATA_WIDTH/8): source stream to the streamer.
REQ-010 SHALL have port cnt_o, output, CNT_WIDTH: beats delivered downstream in the current job.
REQ-011 SHALL have ports busy_o, done_o, overflow_o, all output, 1: FSM busy, one-cycle done pulse, sticky overflow.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-013 In IDLE, start_i=1 SHALL latch len_i and load a zero count; next state is RUN if len_i!=0, DONE if len_i==0.
REQ-014 start_i outside IDLE SHALL be ignored.
REQ-015 Buffering SHALL be a 2-entry registered FIFO between the sink and the source.
REQ-016 A sink handshake occurs when in_valid_i & in_ready_o; a source handshake occurs when out_valid_o & out_ready_i.
REQ-017 in_ready_o SHALL be 1 only in RUN with FIFO not full and accepted-beat count < latched length.
REQ-018 Data SHALL pass in order with no loss or duplication.
REQ-019 A beat accepted in cycle N SHALL be presentable on out_data_o in cycle N+1 (latency 1).
REQ-020 With out_ready_i held at 1, throughput SHALL be 1 beat per cycle.
REQ-021 Simultaneous push and pop on a full FIFO SHALL be permitted; the FIFO SHALL never over-run or under-run.
REQ-022 out_valid_o SHALL equal FIFO not empty.
REQ-023 out_data_o and out_valid_o SHALL remain stable while out_valid_o & ~out_ready_i.
REQ-024 out_strb_o SHALL be all-ones constantly.
REQ-025 The accepted-beat counter SHALL increment on each sink handshake.
REQ-026 Transition RUN->DRAIN SHALL occur in the cycle the accepted count reaches the latched length.
REQ-027 cnt_o SHALL increment on each source handshake, saturating at 2^CNT_WIDTH-1.
REQ-028 DRAIN->DONE SHALL occur when the FIFO is empty and no pop is pending.
REQ-029 DONE SHALL last exactly one cycle with done_o=1, then go to IDLE.
REQ-030 busy_o SHALL be 1 in RUN and DRAIN, and 0 otherwise.
REQ-031 overflow_o SHALL set on any cycle where in_valid_i=1 while state is IDLE, DRAIN or DONE.
REQ-032 overflow_o SHALL remain set until clear_i, or an accepted start, or reset.
REQ-033 cnt_o SHALL hold its final value after DONE until the next accepted start or clear_i.
REQ-034 clear_i SHALL take priority over start_i and all FSM transitions.
REQ-035 clear_i SHALL flush the FIFO, zero both counters, clear overflow_o, force IDLE, and produce no done pulse.

Reset
REQ-036 While rst_ni=0, state SHALL be IDLE.
REQ-037 While rst_ni=0, FIFO SHALL be empty.
REQ-038 While rst_ni=0, outputs SHALL be: in_ready_o=0, out_valid_o=0, out_data_o=0, cnt_o=0, busy_o=0, done_o=0, overflow_o=0.
REQ-039 Reset assertion mid-job SHALL abort the job immediately, without waiting for a clock edge.
REQ-040 After reset release, the block SHALL accept a new start on the first clock edge.

Verification
REQ-041 Scenario, streaming job:
- Stimulus: start with len=8; in_valid_i held 1 with data 0..7; out_ready_i held 1.
- Response: out_data_o=0..7 on consecutive cycles; first beat out one cycle after first acceptance; cnt_o=8; done_o pulses once, 1 cycle after last pop; busy_o falls in the done cycle.
REQ-042 Scenario, backpressure:
- Stimulus: len=4; out_ready_i=0 for 5 cycles, then 1.
- Response: in_ready_o drops after 2 accepts; out_data_o stable while stalled; all 4 beats delivered in order; cnt_o=4.
REQ-043 Scenario, zero length:
- Stimulus: start with len=0.
- Response: busy_o stays 0; done_o pulses in the cycle after start; cnt_o=0; no beats accepted.
REQ-044 Scenario, extra beat:
- Stimulus: len=2; 3 input beats offered.
- Response: third beat not accepted; overflow_o=1 and held; it clears on the next accepted start.
REQ-045 Scenario, clear mid-job:
- Stimulus: clear_i asserted in RUN with 2 beats buffered.
- Response: next cycle out_valid_o=0, cnt_o=0, IDLE, no done_o.
- Stimulus: start_i during RUN.
- Response: ignored, latched length unchanged.
REQ-046 Scenario, reset mid-job:
- Stimulus: rst_ni pulsed low asynchronously between clock edges during DRAIN.
- Response: all outputs at reset values immediately; a subsequent len=1 job completes normally.
